timing_sequencer: RTL and testbench
===================================

// Module: timing_sequencer
// PURPOSE
//  Major-cycle timing controller for the PDP-8/I core. Steps time states TS1..TS4,
//  issues one 100 ns TPn pulse at the end of each, and launches the delay line once
//  per cycle (active-low launch, as the delay-line input expects) to time memory.
//  Handles run/stop/single-step and grants data-break cycles at cycle boundaries.
// PARAMETERS
//  TS1_LEN   40  clk cycles in TS1 (10 ns each); legal 2..255, > PULSE_W
//  TS2_LEN   35  clk cycles in TS2
//  TS3_LEN   40  clk cycles in TS3
//  TS4_LEN   35  clk cycles in TS4 (defaults sum to 150 = 1.5 us cycle)
//  PULSE_W   10  width of TPn and dl_launch_n pulses, clk cycles; legal 1..TSn_LEN-1
// PORTS
//  clk          in   1  100 MHz system clock
//  rst          in   1  synchronous, active-high reset
//  run_req      in   1  level; start running when sampled high in IDLE
//  stop_req     in   1  pulse; halt at end of the current cycle
//  single_step  in   1  level; if high, halt after every cycle
//  break_req    in   1  level; data-break request
//  ts           out  4  one-hot time-state level {ts4,ts3,ts2,ts1}; 0 in IDLE
//  tp           out  4  one-hot time pulses {tp4,tp3,tp2,tp1}
//  dl_launch_n  out  1  active-low delay-line launch
//  run          out  1  high while sequencing
//  break_grant  out  1  high for a whole cycle (TS1..TS4) granted to the break
// BEHAVIOUR
//  Reset (sync, overrides all): state=IDLE, ts=0, tp=0, dl_launch_n=1, run=0,
//   break_grant=0, stop_pend=0, cnt=0. Reset mid-cycle aborts with no further pulses.
//  States: IDLE, TS1, TS2, TS3, TS4. 8-bit down-counter cnt.
//  IDLE: if run_req=1 -> TS1 next clk, run<=1, cnt<=TS1_LEN-1.
//  TSn: cnt decrements each clk; at cnt==0 move to TS(n+1), load TS(n+1)_LEN-1.
//   ts[n-1]=1 for exactly TSn_LEN clks.
//  tp[n-1]=1 during the final PULSE_W clks of TSn (cnt<PULSE_W); never overlaps.
//  dl_launch_n=0 for the first PULSE_W clks of TS1 (cnt>TS1_LEN-1-PULSE_W).
//  End of TS4 (cnt==0): if stop_pend or single_step -> IDLE, run<=0, stop_pend<=0,
//   break_grant<=0; else -> TS1 (no idle gap), break_grant<=break_req.
//  break_grant also set from break_req on IDLE->TS1. Changes only at cycle boundary;
//   break_req dropping mid-cycle does not shorten the grant.
//  stop_req: sets stop_pend on any clk while run=1 or on the IDLE->TS1 transition;
//   ignored in IDLE otherwise. Same-clk run_req+stop_req in IDLE: exactly one cycle.
//  stop_req repeated while pending: no effect. run_req ignored while run=1.
//  All outputs registered; one-clk latency from sampled input to state change.
// TESTING
//  1 Reset: hold rst 3 clks mid-TS2 -> next clk all outputs at reset values, IDLE.
//  2 run_req=1 one clk, single_step=1 -> ts1 40 clks, ts2 35, ts3 40, ts4 35; each tp
//    10 clks at end of its state; dl_launch_n low clks 1..10; run falls after 150.
//  3 Free run, stop_req pulse at clk 60 of cycle 2 -> cycle 2 completes, run=0 at
//    clk 300, no tp1 afterwards; stop_pend cleared.
//  4 break_req raised mid-TS3 of cycle 1, dropped mid-TS2 of cycle 2 -> break_grant=1
//    exactly clks 150..299, 0 from 300.
//  5 IDLE with run_req and stop_req same clk -> exactly one 150-clk cycle, then IDLE.
//  6 Back-to-back run: check TS4->TS1 continuity (no gap) and 4 tp pulses per cycle.

Source files
------------

// File: rtl/timing_sequencer.sv
// Major-cycle timing sequencer for the PDP-8/I core.
// Steps TS1..TS4 with a down-counter, emits one TPn pulse at the tail of each
// time state, launches the memory delay line at the head of TS1, and handles
// run/stop/single-step plus data-break grants at cycle boundaries.
// Every output is a flop fed from the next-state logic, so outputs change on
// the same clock edge as the state register.
module timing_sequencer #(
    parameter int TS1_LEN = 40,
    parameter int TS2_LEN = 35,
    parameter int TS3_LEN = 40,
    parameter int TS4_LEN = 35,
    parameter int PULSE_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_req,
    input  logic       stop_req,
    input  logic       single_step,
    input  logic       break_req,
    output logic [3:0] ts,
    output logic [3:0] tp,
    output logic       dl_launch_n,
    output logic       run,
    output logic       break_grant
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TS1,
        S_TS2,
        S_TS3,
        S_TS4
    } state_t;

    localparam logic [7:0] TS1_LAST = 8'(TS1_LEN - 1);
    localparam logic [7:0] TS2_LAST = 8'(TS2_LEN - 1);
    localparam logic [7:0] TS3_LAST = 8'(TS3_LEN - 1);
    localparam logic [7:0] TS4_LAST = 8'(TS4_LEN - 1);
    localparam logic [7:0] PW       = 8'(PULSE_W);
    // Counter values above this threshold are the first PULSE_W clocks of TS1.
    localparam logic [7:0] DL_TH    = 8'(TS1_LEN - 1 - PULSE_W);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       stop_pend, stop_pend_n;
    logic       run_n, break_grant_n;
    logic [3:0] ts_n, tp_n;
    logic       dl_launch_n_n;

    // Next-state, counter and next-output logic for the time-state sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        state_n       = state;
        cnt_n         = cnt;
        run_n         = run;
        break_grant_n = break_grant;
        stop_pend_n   = stop_pend;
        ts_n          = 4'b0000;
        tp_n          = 4'b0000;
        dl_launch_n_n = 1'b1;

        // A stop request while running is remembered until the cycle ends.
        if (run && stop_req) begin
            stop_pend_n = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (run_req) begin
                    state_n       = S_TS1;
                    cnt_n         = TS1_LAST;
                    run_n         = 1'b1;
                    break_grant_n = break_req;
                    stop_pend_n   = stop_req;
                end
            end
            S_TS1: begin
                if (cnt == 8'd0) begin
                    state_n = S_TS2;
                    cnt_n   = TS2_LAST;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_TS2: begin
                if (cnt == 8'd0) begin
                    state_n = S_TS3;
                    cnt_n   = TS3_LAST;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_TS3: begin
                if (cnt == 8'd0) begin
                    state_n = S_TS4;
                    cnt_n   = TS4_LAST;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_TS4: begin
                if (cnt == 8'd0) begin
                    if (stop_pend || single_step) begin
                        state_n       = S_IDLE;
                        cnt_n         = 8'd0;
                        run_n         = 1'b0;
                        stop_pend_n   = 1'b0;
                        break_grant_n = 1'b0;
                    end else begin
                        // Straight into the next cycle, no idle gap.
                        state_n       = S_TS1;
                        cnt_n         = TS1_LAST;
                        break_grant_n = break_req;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 8'd0;
            end
        endcase

        // Outputs are decoded from the next state so they land in flops.
        case (state_n)
            S_TS1:   ts_n = 4'b0001;
            S_TS2:   ts_n = 4'b0010;
            S_TS3:   ts_n = 4'b0100;
            S_TS4:   ts_n = 4'b1000;
            default: ts_n = 4'b0000;
        endcase

        if (cnt_n < PW) begin
            tp_n = ts_n;
        end

        if ((state_n == S_TS1) && (cnt_n > DL_TH)) begin
            dl_launch_n_n = 1'b0;
        end
    end

    // State, counter and registered outputs; synchronous reset wins over all.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            stop_pend   <= 1'b0;
            run         <= 1'b0;
            break_grant <= 1'b0;
            ts          <= 4'b0000;
            tp          <= 4'b0000;
            dl_launch_n <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            stop_pend   <= stop_pend_n;
            run         <= run_n;
            break_grant <= break_grant_n;
            ts          <= ts_n;
            tp          <= tp_n;
            dl_launch_n <= dl_launch_n_n;
        end
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer with default parameters (150-clk cycle).
// Clock index k = 0 is the first clock with ts1 high after a start request.
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
module tb_timing_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run_req;
    logic       stop_req;
    logic       single_step;
    logic       break_req;
    logic [3:0] ts;
    logic [3:0] tp;
    logic       dl_launch_n;
    logic       run;
    logic       break_grant;

    int checks = 0;
    int errors = 0;

    timing_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run_req     (run_req),
        .stop_req    (stop_req),
        .single_step (single_step),
        .break_req   (break_req),
        .ts          (ts),
        .tp          (tp),
        .dl_launch_n (dl_launch_n),
        .run         (run),
        .break_grant (break_grant)
    );

    always #5 clk = ~clk;

    // Hand-derived cycle map: TS1 0..39, TS2 40..74, TS3 75..114, TS4 115..149.
    // tp at 30..39, 65..74, 105..114, 140..149; delay-line launch at 0..9.
    function automatic logic [9:0] exp_out(input int p, input bit act);
        logic [3:0] e_ts;
        logic [3:0] e_tp;
        logic       e_dl;
        if (!act) return {4'b0000, 4'b0000, 1'b1, 1'b0};
        if (p < 40)       e_ts = 4'b0001;
        else if (p < 75)  e_ts = 4'b0010;
        else if (p < 115) e_ts = 4'b0100;
        else              e_ts = 4'b1000;
        if ((p >= 30 && p < 40) || (p >= 65 && p < 75) ||
            (p >= 105 && p < 115) || (p >= 140))
            e_tp = e_ts;
        else
            e_tp = 4'b0000;
        e_dl = (p < 10) ? 1'b0 : 1'b1;
        return {e_ts, e_tp, e_dl, 1'b1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ts, tp, dl_launch_n, run, break_grant} !== 11'b0000_0000_1_0_0) begin
            errors++;
            $display("FAIL reset_init: got %b expected %b",
                     {ts, tp, dl_launch_n, run, break_grant}, 11'b0000_0000_1_0_0);
        end
        // Start a cycle and reset it mid-TS2 at k = 50.
        start_run();
        repeat (50) tick();
        checks++;
        if (ts !== 4'b0010) begin
            errors++;
            $display("FAIL reset_pre_ts2: ts got %b expected 0010", ts);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ts, tp, dl_launch_n, run, break_grant} !== 11'b0000_0000_1_0_0) begin
            errors++;
            $display("FAIL reset_first_edge: got %b expected %b",
                     {ts, tp, dl_launch_n, run, break_grant}, 11'b0000_0000_1_0_0);
        end
        tick();
        tick();
        rst = 1'b0;
        // No further pulses after the abort.
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({ts, tp, dl_launch_n, run, break_grant} !== 11'b0000_0000_1_0_0) begin
                errors++;
                $display("FAIL reset_idle_after i=%0d: got %b expected %b", i,
                         {ts, tp, dl_launch_n, run, break_grant}, 11'b0000_0000_1_0_0);
            end
        end
    endtask

    task automatic test_single_step();
        int ts_cnt[4];
        int tp_cnt[4];
        int dl_cnt;
        logic [9:0] e;
        for (int b = 0; b < 4; b++) begin
            ts_cnt[b] = 0;
            tp_cnt[b] = 0;
        end
        dl_cnt = 0;
        single_step = 1'b1;
        start_run();
        for (int k = 0; k <= 160; k++) begin
            e = exp_out(k, k < 150);
            checks++;
            if ({ts, tp, dl_launch_n, run} !== e) begin
                errors++;
                $display("FAIL single_step k=%0d: got %b expected %b", k,
                         {ts, tp, dl_launch_n, run}, e);
            end
            for (int b = 0; b < 4; b++) begin
                if (ts[b] === 1'b1) ts_cnt[b]++;
                if (tp[b] === 1'b1) tp_cnt[b]++;
            end
            if (dl_launch_n === 1'b0) dl_cnt++;
            tick();
        end
        single_step = 1'b0;
        checks++;
        if (ts_cnt[0] != 40 || ts_cnt[1] != 35 || ts_cnt[2] != 40 || ts_cnt[3] != 35) begin
            errors++;
            $display("FAIL single_step_ts_len: got %0d/%0d/%0d/%0d expected 40/35/40/35",
                     ts_cnt[0], ts_cnt[1], ts_cnt[2], ts_cnt[3]);
        end
        checks++;
        if (tp_cnt[0] != 10 || tp_cnt[1] != 10 || tp_cnt[2] != 10 || tp_cnt[3] != 10 ||
            dl_cnt != 10) begin
            errors++;
            $display("FAIL single_step_pulse_w: tp %0d/%0d/%0d/%0d dl %0d expected all 10",
                     tp_cnt[0], tp_cnt[1], tp_cnt[2], tp_cnt[3], dl_cnt);
        end
    endtask

    task automatic test_stop();
        logic [9:0] e;
        bit         done;
        start_run();
        for (int k = 0; k <= 400; k++) begin
            e = exp_out(k % 150, k < 300);
            checks++;
            if ({ts, tp, dl_launch_n, run} !== e) begin
                errors++;
                $display("FAIL stop k=%0d: got %b expected %b", k,
                         {ts, tp, dl_launch_n, run}, e);
            end
            stop_req = (k == 210);
            tick();
        end
        stop_req = 1'b0;
        // A fresh free run must not inherit a stale pending stop.
        start_run();
        repeat (160) tick();
        checks++;
        if (run !== 1'b1 || ts !== 4'b0001) begin
            errors++;
            $display("FAIL stop_pend_cleared: run %b ts %b expected run 1 ts 0001", run, ts);
        end
        stop_req = 1'b1;
        tick();
        stop_req = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (run === 1'b0) done = 1'b1;
            else tick();
        end
        checks++;
        if (!done || ts !== 4'b0000) begin
            errors++;
            $display("FAIL stop_restart_halt: run %b ts %b expected run 0 ts 0000", run, ts);
        end
    endtask

    task automatic test_break();
        logic exp_bg;
        start_run();
        for (int k = 0; k <= 310; k++) begin
            exp_bg = (k >= 150 && k < 300);
            checks++;
            if (break_grant !== exp_bg) begin
                errors++;
                $display("FAIL break_grant k=%0d: got %b expected %b", k, break_grant, exp_bg);
            end
            break_req = (k >= 90 && k < 200);
            stop_req  = (k == 160);
            tick();
        end
        break_req = 1'b0;
        stop_req  = 1'b0;
        checks++;
        if (run !== 1'b0) begin
            errors++;
            $display("FAIL break_end_idle: run got %b expected 0", run);
        end
    endtask

    task automatic test_same_clk();
        logic [9:0] e;
        run_req  = 1'b1;
        stop_req = 1'b1;
        tick();
        run_req  = 1'b0;
        stop_req = 1'b0;
        for (int k = 0; k <= 170; k++) begin
            e = exp_out(k, k < 150);
            checks++;
            if ({ts, tp, dl_launch_n, run} !== e) begin
                errors++;
                $display("FAIL same_clk k=%0d: got %b expected %b", k,
                         {ts, tp, dl_launch_n, run}, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int         rises[4];
        logic [3:0] tp_prev;
        logic [9:0] e;
        for (int b = 0; b < 4; b++) rises[b] = 0;
        tp_prev = 4'b0000;
        start_run();
        for (int k = 0; k <= 455; k++) begin
            e = exp_out(k % 150, k < 450);
            checks++;
            if ({ts, tp, dl_launch_n, run} !== e) begin
                errors++;
                $display("FAIL back_to_back k=%0d: got %b expected %b", k,
                         {ts, tp, dl_launch_n, run}, e);
            end
            for (int b = 0; b < 4; b++)
                if (tp[b] === 1'b1 && tp_prev[b] === 1'b0) rises[b]++;
            tp_prev = tp;
            stop_req = (k == 310);
            tick();
        end
        stop_req = 1'b0;
        checks++;
        if (rises[0] != 3 || rises[1] != 3 || rises[2] != 3 || rises[3] != 3) begin
            errors++;
            $display("FAIL back_to_back_tp_count: got %0d/%0d/%0d/%0d expected 3/3/3/3",
                     rises[0], rises[1], rises[2], rises[3]);
        end
    endtask

    initial begin
        rst         = 1'b0;
        run_req     = 1'b0;
        stop_req    = 1'b0;
        single_step = 1'b0;
        break_req   = 1'b0;
        #2;
        test_reset();
        test_single_step();
        test_stop();
        repeat (5) tick();
        test_break();
        repeat (5) tick();
        test_same_clk();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
